// File: rtl/regfile_wb_sequencer.sv
// regfile_wb_sequencer: merges ALU and buffered load results into one registered register-file write per cycle
module regfile_wb_sequencer #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  output logic [4:0]  writeRegSel,
  output logic [31:0] writeData,
  output logic        writeEn,
  output logic [31:0] pend_mask,
  output logic        err
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [4:0]       rd_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0]    head, tail;
  logic [AW:0]      count;
  logic [SW-1:0]    starve;
  logic             nonempty, force_pop, alu_hs, alu_win, pop, push;
  assign nonempty  = count != '0;
  assign force_pop = nonempty && starve == SW'(STARVE_MAX);
  assign alu_ready = !force_pop;
  assign lsu_ready = count < (AW+1)'(DEPTH);
  assign alu_hs    = alu_valid && alu_ready;
  assign alu_win   = alu_hs && alu_rd != '0;
  // a consumed x0 ALU op still blocks the FIFO for that cycle
  assign pop       = nonempty && !alu_hs;
  assign push      = lsu_valid && lsu_ready && lsu_rd != '0;
  // pending mask: one-hot of every valid FIFO entry's destination
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) if (vld[i]) pend_mask[rd_q[i]] = 1'b1;
  end
  // FIFO payload storage; contents are qualified by vld so need no reset
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[tail]   <= lsu_rd;
      data_q[tail] <= lsu_data;
    end
  end
  // FIFO pointers, occupancy, valid bits and starvation counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      vld    <= '0;
      starve <= '0;
    end else begin
      if (push) begin
        tail      <= tail + AW'(1);
        vld[tail] <= 1'b1;
      end
      if (pop) begin
        head      <= head + AW'(1);
        vld[head] <= 1'b0;
      end
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
      starve <= (!nonempty || pop) ? '0 : (starve == SW'(STARVE_MAX) ? starve : starve + SW'(1));
    end
  end
  // registered write port and sticky ordering-violation flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      writeEn     <= 1'b0;
      writeRegSel <= '0;
      writeData   <= '0;
      err         <= 1'b0;
    end else begin
      writeEn <= alu_win || pop;
      if (alu_win) begin
        writeRegSel <= alu_rd;
        writeData   <= alu_data;
      end else if (pop) begin
        writeRegSel <= rd_q[head];
        writeData   <= data_q[head];
      end
      err <= err || (alu_win && pend_mask[alu_rd]);
    end
  end
endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// tb_regfile_wb_sequencer: directed scenario tests for the write-back sequencer
module tb_regfile_wb_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_valid = 1'b0, alu_ready;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        lsu_valid = 1'b0, lsu_ready;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_data = '0;
  logic [4:0]  writeRegSel;
  logic [31:0] writeData;
  logic        writeEn;
  logic [31:0] pend_mask;
  logic        err;
  int checks = 0;
  int errors = 0;

  regfile_wb_sequencer #(.DEPTH(4), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .writeRegSel(writeRegSel), .writeData(writeData), .writeEn(writeEn),
    .pend_mask(pend_mask), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) step();
    rst = 1'b1;
    repeat (5) step();
    checks++; if (writeEn !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", writeEn); end
    checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL reset_lsu_ready got %b want 1", lsu_ready); end
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL reset_alu_ready got %b want 1", alu_ready); end
    checks++; if (pend_mask !== 32'h0) begin errors++; $display("FAIL reset_pend got %h want 0", pend_mask); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (writeRegSel !== 5'd0 || writeData !== 32'h0) begin errors++; $display("FAIL reset_out got %0d/%h want 0/0", writeRegSel, writeData); end
  endtask

  task automatic test_alu();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    alu_valid = 1'b0;
    checks++; if (writeEn !== 1'b1 || writeRegSel !== 5'd5 || writeData !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_write got %b/%0d/%h want 1/5/deadbeef", writeEn, writeRegSel, writeData); end
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h12345678;
    step();
    alu_valid = 1'b0;
    checks++; if (writeEn !== 1'b0) begin errors++; $display("FAIL alu_x0 got %b want 0", writeEn); end
    checks++; if (writeRegSel !== 5'd5 || writeData !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_hold got %0d/%h want 5/deadbeef", writeRegSel, writeData); end
    step();
    checks++; if (writeEn !== 1'b0) begin errors++; $display("FAIL alu_idle got %b want 0", writeEn); end
  endtask

  // ALU kept busy on rd=20 while the loads arrive so the FIFO can actually fill
  task automatic test_fill_drain();
    logic [31:0] exp_pend [4] = '{32'h02, 32'h06, 32'h0E, 32'h1E};
    for (int i = 1; i <= 4; i++) begin
      alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'hA00 + i;
      lsu_valid = 1'b1; lsu_rd = 5'(i); lsu_data = 32'h100 + i;
      step();
      checks++; if (pend_mask !== exp_pend[i-1]) begin errors++; $display("FAIL fill_pend%0d got %h want %h", i, pend_mask, exp_pend[i-1]); end
      checks++; if (writeEn !== 1'b1 || writeRegSel !== 5'd20 || writeData !== 32'hA00 + i) begin errors++; $display("FAIL fill_alu%0d got %b/%0d/%h want 1/20/%h", i, writeEn, writeRegSel, writeData, 32'hA00 + i); end
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    checks++; if (lsu_ready !== 1'b0) begin errors++; $display("FAIL full_lsu_ready got %b want 0", lsu_ready); end
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL full_force got %b want 0", alu_ready); end
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++; if (writeEn !== 1'b1 || writeRegSel !== 5'(i) || writeData !== 32'h100 + i) begin errors++; $display("FAIL drain%0d got %b/%0d/%h want 1/%0d/%h", i, writeEn, writeRegSel, writeData, i, 32'h100 + i); end
      checks++; if (pend_mask !== (32'h1E & ~((32'h2 << i) - 32'h2))) begin errors++; $display("FAIL drain_pend%0d got %h want %h", i, pend_mask, 32'h1E & ~((32'h2 << i) - 32'h2)); end
    end
    step();
    checks++; if (writeEn !== 1'b0 || lsu_ready !== 1'b1) begin errors++; $display("FAIL drain_idle got we=%b rdy=%b want 0/1", writeEn, lsu_ready); end
  endtask

  task automatic test_starvation();
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h77;
    step();
    lsu_valid = 1'b0;
    checks++; if (pend_mask !== 32'h80) begin errors++; $display("FAIL starve_pend got %h want 80", pend_mask); end
    alu_valid = 1'b1; alu_rd = 5'd9;
    for (int k = 0; k < 3; k++) begin
      alu_data = 32'h900 + k;
      checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL starve_ready%0d got %b want 1", k, alu_ready); end
      step();
      checks++; if (writeEn !== 1'b1 || writeRegSel !== 5'd9 || writeData !== 32'h900 + k) begin errors++; $display("FAIL starve_alu%0d got %b/%0d/%h want 1/9/%h", k, writeEn, writeRegSel, writeData, 32'h900 + k); end
    end
    alu_data = 32'h903;
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL starve_force got %b want 0", alu_ready); end
    step();
    checks++; if (writeEn !== 1'b1 || writeRegSel !== 5'd7 || writeData !== 32'h77) begin errors++; $display("FAIL starve_pop got %b/%0d/%h want 1/7/77", writeEn, writeRegSel, writeData); end
    checks++; if (alu_ready !== 1'b1 || pend_mask !== 32'h0) begin errors++; $display("FAIL starve_restart got rdy=%b pend=%h want 1/0", alu_ready, pend_mask); end
    step();
    alu_valid = 1'b0;
    checks++; if (writeEn !== 1'b1 || writeRegSel !== 5'd9 || writeData !== 32'h903) begin errors++; $display("FAIL starve_resume got %b/%0d/%h want 1/9/903", writeEn, writeRegSel, writeData); end
    step();
  endtask

  task automatic test_order_err();
    lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 32'h66;
    step();
    lsu_valid = 1'b0;
    checks++; if (err !== 1'b0 || pend_mask !== 32'h40) begin errors++; $display("FAIL err_pre got err=%b pend=%h want 0/40", err, pend_mask); end
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'hABC;
    step();
    alu_valid = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", err); end
    checks++; if (writeEn !== 1'b1 || writeRegSel !== 5'd6 || writeData !== 32'hABC) begin errors++; $display("FAIL err_write got %b/%0d/%h want 1/6/abc", writeEn, writeRegSel, writeData); end
    step();
    checks++; if (writeEn !== 1'b1 || writeRegSel !== 5'd6 || writeData !== 32'h66) begin errors++; $display("FAIL err_pop got %b/%0d/%h want 1/6/66", writeEn, writeRegSel, writeData); end
    repeat (3) step();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err); end
    #2 rst = 1'b0;
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", err); end
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_rd = 5'd21; alu_data = 32'hB00 + i;
      lsu_valid = 1'b1; lsu_rd = 5'(10 + i); lsu_data = 32'hC00 + i;
      step();
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    checks++; if (lsu_ready !== 1'b0 || pend_mask !== 32'h3C00 || writeEn !== 1'b1) begin errors++; $display("FAIL mid_full got rdy=%b pend=%h we=%b want 0/3c00/1", lsu_ready, pend_mask, writeEn); end
    #2 rst = 1'b0;
    #1;
    checks++; if (writeEn !== 1'b0) begin errors++; $display("FAIL mid_cancel got %b want 0", writeEn); end
    checks++; if (pend_mask !== 32'h0 || lsu_ready !== 1'b1 || alu_ready !== 1'b1) begin errors++; $display("FAIL mid_flush got pend=%h rdy=%b/%b want 0/1/1", pend_mask, lsu_ready, alu_ready); end
    step();
    #3 rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (writeEn !== 1'b0 || pend_mask !== 32'h0) begin errors++; $display("FAIL mid_stale%0d got we=%b pend=%h want 0/0", k, writeEn, pend_mask); end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_fill_drain();
    test_starvation();
    test_order_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
